sram_multiport: RTL and testbench

//  Multi-port arbitrated front end for the asynchronous 16-bit SRAM behind the ADR/DAT/RAMxx pins.
//  N_PORTS requesters (VGA line fetch, pen/camera writer, ...) each issue single-word read/write requests.
//  An arbiter picks one, and a sequencer drives the SRAM pins with a configurable access time.

---
 rtl/sram_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/sram_multiport.sv | 180 ++++++++++++++++++
 tb/tb_sram_multiport.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and default widths for the multi-port SRAM front end.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StFinish
  } sram_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin from last_grant+1, or fixed lowest-index priority.
module rr_arbiter #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned RR_MODE = 1,
  localparam int unsigned IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [N_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               valid
);

  int unsigned cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    valid   = 1'b0;
    cand    = 0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      // Candidate order wraps modulo N_PORTS; it never exceeds 2*N_PORTS-1.
      cand = ((RR_MODE != 0) ? 32'(last_grant) + 1 : 0) + i;
      if (cand >= N_PORTS) begin
        cand = cand - N_PORTS;
      end
      if (!valid && req[IDX_W'(cand)]) begin
        valid              = 1'b1;
        gnt_idx            = IDX_W'(cand);
        gnt[IDX_W'(cand)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_multiport.sv
// Arbitrated multi-requester front end driving an asynchronous SRAM with registered strobes.
module sram_multiport
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W      = SRAM_ADDR_W,
  parameter int unsigned DATA_W      = SRAM_DATA_W,
  parameter int unsigned N_PORTS     = 2,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned RR_MODE     = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PORTS-1:0]        req,
  input  logic [N_PORTS-1:0]        we,
  input  logic [N_PORTS*ADDR_W-1:0] addr,
  input  logic [N_PORTS*DATA_W-1:0] wdata,
  output logic [N_PORTS-1:0]        gnt,
  output logic [N_PORTS-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         address_pins,
  output logic [DATA_W-1:0]         data_pins_out,
  input  logic [DATA_W-1:0]         data_pins_in,
  output logic                      data_pins_out_en,
  output logic                      OE,
  output logic                      WE,
  output logic                      CS
);

  localparam int unsigned IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);

  sram_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [N_PORTS-1:0] sel_q, sel_d;
  logic               wr_q, wr_d;
  logic [N_PORTS-1:0] gnt_q, gnt_d;
  logic [N_PORTS-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               oen_q, oen_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;
  logic               cs_q, cs_d;

  logic [N_PORTS-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  logic [ADDR_W-1:0] addr_arr  [N_PORTS];
  logic [DATA_W-1:0] wdata_arr [N_PORTS];

  for (genvar g = 0; g < N_PORTS; g++) begin : g_unpack
    assign addr_arr[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = wdata[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N_PORTS (N_PORTS),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .req        (req),
    .last_grant (ptr_q),
    .gnt        (arb_gnt),
    .gnt_idx    (arb_idx),
    .valid      (arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    wr_d     = wr_q;
    gnt_d    = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    dout_d   = dout_q;
    oen_d    = oen_q;
    oe_d     = oe_q;
    we_n_d   = we_n_q;
    cs_d     = cs_q;
    case (state_q)
      StIdle, StFinish: begin
        oe_d   = 1'b1;
        we_n_d = 1'b1;
        if (arb_valid) begin
          state_d = StSetup;
          gnt_d   = arb_gnt;
          sel_d   = arb_gnt;
          ptr_d   = arb_idx;
          wr_d    = we[arb_idx];
          addr_d  = addr_arr[arb_idx];
          cs_d    = 1'b0;
          oen_d   = we[arb_idx];
          if (we[arb_idx]) begin
            dout_d = wdata_arr[arb_idx];
          end
        end else begin
          state_d = StIdle;
          cs_d    = 1'b1;
          oen_d   = 1'b0;
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
        if (wr_q) begin
          we_n_d = 1'b0;
        end else begin
          oe_d = 1'b0;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d = StFinish;
          oe_d    = 1'b1;
          we_n_d  = 1'b1;
          if (!wr_q) begin
            rdata_d  = data_pins_in;
            rvalid_d = sel_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset drops any in-flight access; the pointer starts at the last port so port 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ptr_q    <= IDX_W'(N_PORTS - 1);
      sel_q    <= '0;
      wr_q     <= 1'b0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      dout_q   <= '0;
      oen_q    <= 1'b0;
      oe_q     <= 1'b1;
      we_n_q   <= 1'b1;
      cs_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      sel_q    <= sel_d;
      wr_q     <= wr_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      oen_q    <= oen_d;
      oe_q     <= oe_d;
      we_n_q   <= we_n_d;
      cs_q     <= cs_d;
    end
  end

  assign gnt              = gnt_q;
  assign rvalid           = rvalid_q;
  assign rdata            = rdata_q;
  assign busy             = (state_q != StIdle);
  assign address_pins     = addr_q;
  assign data_pins_out    = dout_q;
  assign data_pins_out_en = oen_q;
  assign OE               = oe_q;
  assign WE               = we_n_q;
  assign CS               = cs_q;

endmodule

// File: tb/tb_sram_multiport.sv
// Directed bench: main instance (W=1, RR), fixed-priority instance and W=3 instance share stimulus.
module tb_sram_multiport;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, we;
  logic [35:0] addr;
  logic [31:0] wdata;

  logic [1:0]  m_gnt, m_rvalid, fp_gnt, fp_rvalid, w3_gnt, w3_rvalid;
  logic [15:0] m_rdata, m_dout, m_din, fp_rdata, fp_dout, w3_rdata, w3_dout, w3_din;
  logic [17:0] m_apins, fp_apins, w3_apins;
  logic        m_busy, m_oen, m_oe, m_we, m_cs;
  logic        fp_busy, fp_oen, fp_oe, fp_we, fp_cs;
  logic        w3_busy, w3_oen, w3_oe, w3_we, w3_cs;

  int n_checks, n_errors, proto_err;
  logic [15:0] mem [logic [17:0]];
  logic        prev_we;

  always #5 clk = ~clk;

  sram_multiport #(.N_PORTS(2), .WAIT_CYCLES(1), .RR_MODE(1)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(m_gnt), .rvalid(m_rvalid), .rdata(m_rdata), .busy(m_busy), .address_pins(m_apins),
    .data_pins_out(m_dout), .data_pins_in(m_din), .data_pins_out_en(m_oen),
    .OE(m_oe), .WE(m_we), .CS(m_cs));

  sram_multiport #(.N_PORTS(2), .WAIT_CYCLES(1), .RR_MODE(0)) dut_fp (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(fp_gnt), .rvalid(fp_rvalid), .rdata(fp_rdata), .busy(fp_busy), .address_pins(fp_apins),
    .data_pins_out(fp_dout), .data_pins_in(16'h0000), .data_pins_out_en(fp_oen),
    .OE(fp_oe), .WE(fp_we), .CS(fp_cs));

  sram_multiport #(.N_PORTS(2), .WAIT_CYCLES(3), .RR_MODE(1)) dut_w3 (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(w3_gnt), .rvalid(w3_rvalid), .rdata(w3_rdata), .busy(w3_busy), .address_pins(w3_apins),
    .data_pins_out(w3_dout), .data_pins_in(w3_din), .data_pins_out_en(w3_oen),
    .OE(w3_oe), .WE(w3_we), .CS(w3_cs));

  // Simple read pattern for the W=3 instance: data = low address bits ^ 0x5A5A.
  assign w3_din = (w3_cs === 1'b0 && w3_oe === 1'b0) ? (w3_apins[15:0] ^ 16'h5A5A) : 16'h0000;

  // Async SRAM model for the main instance: commits on WE rising, checks strobe ordering.
  always @(negedge clk) begin
    if (m_cs === 1'b0 && m_oe === 1'b0 && m_we === 1'b0) proto_err++;
    if ((m_oe === 1'b0 || m_we === 1'b0) && m_cs === 1'b1) proto_err++;
    if (m_we === 1'b0 && m_oen !== 1'b1) proto_err++;
    if (prev_we === 1'b0 && m_we === 1'b1 && m_cs === 1'b0) begin
      if (m_oen !== 1'b1) proto_err++;
      mem[m_apins] = m_dout;
    end
    prev_we = m_we;
    if (m_cs === 1'b0 && m_oe === 1'b0) m_din = mem.exists(m_apins) ? mem[m_apins] : 16'h0000;
    else m_din = 16'hDEAD;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 2'b00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_port(input int p, input logic w, input logic [17:0] a, input logic [15:0] d);
    if (p == 0) begin
      we[0] = w; addr[17:0] = a; wdata[15:0] = d;
    end else begin
      we[1] = w; addr[35:18] = a; wdata[31:16] = d;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || fp_busy || w3_busy) && n < 40) begin
      tick();
      n++;
    end
    n_checks++;
    if (m_busy || fp_busy || w3_busy) begin
      n_errors++;
      $display("FAIL wait_idle busy got %b%b%b want 000", m_busy, fp_busy, w3_busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({m_cs, m_oe, m_we, m_oen} !== 4'b1110) begin
      n_errors++; $display("FAIL reset_strobes got %b want 1110", {m_cs, m_oe, m_we, m_oen});
    end
    n_checks++;
    if ({m_gnt, m_rvalid, m_busy} !== 5'b00000) begin
      n_errors++; $display("FAIL reset_ctrl got %b want 00000", {m_gnt, m_rvalid, m_busy});
    end
    n_checks++;
    if (m_rdata !== 16'h0 || m_apins !== 18'h0) begin
      n_errors++; $display("FAIL reset_data got %h/%h want 0/0", m_rdata, m_apins);
    end
  endtask

  task automatic test_read();
    logic [1:0] eg [4] = '{2'b01, 2'b00, 2'b00, 2'b00};
    logic       eo [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0] er [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
    logic       eb [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    mem[18'h00010] = 16'hBEEF;
    set_port(0, 1'b0, 18'h00010, 16'h0);
    req = 2'b01;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) req = 2'b00;
      n_checks++;
      if (m_gnt !== eg[c-1]) begin
        n_errors++; $display("FAIL read_gnt c%0d got %b want %b", c, m_gnt, eg[c-1]);
      end
      n_checks++;
      if (m_oe !== eo[c-1]) begin
        n_errors++; $display("FAIL read_oe c%0d got %b want %b", c, m_oe, eo[c-1]);
      end
      n_checks++;
      if (m_rvalid !== er[c-1]) begin
        n_errors++; $display("FAIL read_rvalid c%0d got %b want %b", c, m_rvalid, er[c-1]);
      end
      n_checks++;
      if (m_busy !== eb[c-1]) begin
        n_errors++; $display("FAIL read_busy c%0d got %b want %b", c, m_busy, eb[c-1]);
      end
      if (c == 1) begin
        n_checks++;
        if (m_apins !== 18'h00010 || m_cs !== 1'b0 || m_oen !== 1'b0) begin
          n_errors++; $display("FAIL read_setup got %h cs%b en%b want 00010 cs0 en0",
                               m_apins, m_cs, m_oen);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (m_rdata !== 16'hBEEF) begin
          n_errors++; $display("FAIL read_rdata got %h want beef", m_rdata);
        end
      end
    end
  endtask

  task automatic test_write();
    logic [1:0] eg [4] = '{2'b10, 2'b00, 2'b00, 2'b00};
    logic       ew [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic       ee [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       ec [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    set_port(1, 1'b1, 18'h3FFFF, 16'hA5A5);
    req = 2'b10;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) req = 2'b00;
      n_checks++;
      if ({m_gnt, m_we, m_oen, m_cs} !== {eg[c-1], ew[c-1], ee[c-1], ec[c-1]}) begin
        n_errors++; $display("FAIL write_seq c%0d got %b want %b", c, {m_gnt, m_we, m_oen, m_cs},
                             {eg[c-1], ew[c-1], ee[c-1], ec[c-1]});
      end
      if (c == 1 || c == 3) begin
        n_checks++;
        if (m_apins !== 18'h3FFFF || m_dout !== 16'hA5A5) begin
          n_errors++; $display("FAIL write_pins c%0d got %h/%h want 3ffff/a5a5", c, m_apins, m_dout);
        end
      end
    end
    n_checks++;
    if (!mem.exists(18'h3FFFF) || mem[18'h3FFFF] !== 16'hA5A5) begin
      n_errors++; $display("FAIL write_mem got %h want a5a5",
                           mem.exists(18'h3FFFF) ? mem[18'h3FFFF] : 16'hxxxx);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_m, exp_fp;
    do_reset();
    set_port(0, 1'b0, 18'h00020, 16'h0);
    set_port(1, 1'b0, 18'h00030, 16'h0);
    req = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_m  = (c == 1 || c == 7) ? 2'b01 : ((c == 4 || c == 10) ? 2'b10 : 2'b00);
      exp_fp = (c % 3 == 1) ? 2'b01 : 2'b00;
      n_checks++;
      if (m_gnt !== exp_m) begin
        n_errors++; $display("FAIL rr_gnt c%0d got %b want %b", c, m_gnt, exp_m);
      end
      n_checks++;
      if (fp_gnt !== exp_fp) begin
        n_errors++; $display("FAIL fixed_gnt c%0d got %b want %b", c, fp_gnt, exp_fp);
      end
    end
    req = 2'b00;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [1:0] eg [7] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [1:0] er [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    logic       eb [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       ee [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    set_port(1, 1'b1, 18'h00100, 16'h1234);
    req = 2'b10;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) begin
        set_port(0, 1'b0, 18'h00100, 16'h0);
        req = 2'b01;
      end
      if (c == 4) req = 2'b00;
      n_checks++;
      if ({m_gnt, m_rvalid, m_busy, m_oen} !== {eg[c-1], er[c-1], eb[c-1], ee[c-1]}) begin
        n_errors++; $display("FAIL b2b_seq c%0d got %b want %b", c, {m_gnt, m_rvalid, m_busy, m_oen},
                             {eg[c-1], er[c-1], eb[c-1], ee[c-1]});
      end
      if (c == 6) begin
        n_checks++;
        if (m_rdata !== 16'h1234) begin
          n_errors++; $display("FAIL b2b_rdata got %h want 1234", m_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    set_port(1, 1'b1, 18'h00200, 16'h7777);
    req = 2'b10;
    tick();
    req = 2'b00;
    n_checks++;
    if (m_gnt !== 2'b10) begin
      n_errors++; $display("FAIL midrst_gnt got %b want 10", m_gnt);
    end
    tick();
    n_checks++;
    if (m_we !== 1'b0) begin
      n_errors++; $display("FAIL midrst_access got we %b want 0", m_we);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({m_cs, m_we, m_oe, m_oen, m_busy} !== 5'b11100) begin
      n_errors++; $display("FAIL midrst_pins got %b want 11100", {m_cs, m_we, m_oe, m_oen, m_busy});
    end
    n_checks++;
    if ({m_gnt, m_rvalid} !== 4'b0000 || m_apins !== 18'h0) begin
      n_errors++; $display("FAIL midrst_ctrl got %b/%h want 0000/0", {m_gnt, m_rvalid}, m_apins);
    end
    set_port(0, 1'b0, 18'h00040, 16'h0);
    set_port(1, 1'b0, 18'h00050, 16'h0);
    req = 2'b11;
    tick();
    req = 2'b00;
    n_checks++;
    if (m_gnt !== 2'b01) begin
      n_errors++; $display("FAIL midrst_first_gnt got %b want 01", m_gnt);
    end
    wait_idle();
  endtask

  task automatic test_wait3();
    logic [1:0] exp_rv;
    do_reset();
    set_port(0, 1'b0, 18'h00010, 16'h0);
    req = 2'b01;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) req = 2'b00;
      n_checks++;
      if (w3_gnt !== ((c == 1) ? 2'b01 : 2'b00)) begin
        n_errors++; $display("FAIL w3_gnt c%0d got %b", c, w3_gnt);
      end
      n_checks++;
      if (w3_oe !== ((c >= 2 && c <= 4) ? 1'b0 : 1'b1)) begin
        n_errors++; $display("FAIL w3_oe c%0d got %b", c, w3_oe);
      end
      exp_rv = (c == 5) ? 2'b01 : 2'b00;
      n_checks++;
      if (w3_rvalid !== exp_rv) begin
        n_errors++; $display("FAIL w3_rvalid c%0d got %b want %b", c, w3_rvalid, exp_rv);
      end
      n_checks++;
      if (w3_busy !== (c <= 5)) begin
        n_errors++; $display("FAIL w3_busy c%0d got %b want %b", c, w3_busy, c <= 5);
      end
      if (c == 5) begin
        n_checks++;
        if (w3_rdata !== 16'h5A4A) begin
          n_errors++; $display("FAIL w3_rdata got %h want 5a4a", w3_rdata);
        end
      end
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (proto_err !== 0) begin
      n_errors++; $display("FAIL strobe_protocol got %0d violations want 0", proto_err);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    proto_err = 0;
    reset     = 1'b1;
    req       = 2'b00;
    we        = 2'b00;
    addr      = '0;
    wdata     = '0;
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_access();
    test_wait3();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
